fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Single-port framebuffer arbiter for the LED matrix driver. It shares one 1024×16 RGB565 pixel memory, with a synchronous write and a 1-cycle registered read, between two requesters:
- the panel scan engine, which reads pixels for the row currently being shifted out;
- a host port (UART/SPI loader) that writes and reads back pixels.

The scan engine has absolute priority so panel refresh timing never slips. Host accesses use a valid/ready handshake, and host starvation is flagged.

## Interface
Parameters:
- AW, 10, pixel address width (1024 words).
- DW, 16, pixel data width (RGB565: R=[15:11], G=[10:5], B=[4:0]).
- STARVE_LIMIT, 64, consecutive blocked host cycles before host_starved sets; legal range 1..255.
- WBUF_DEPTH, 4, write-buffer entries; power of two, used only with FB_WBUF_EN.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk, in, 1, system clock; all state updates on posedge.
  - rst, in, 1, asynchronous active-high reset.
- Scan port:
  - scan_req, in, 1, scan engine read request this cycle.
  - scan_addr, in, AW, scan read address.
  - scan_valid, out, 1, scan_data holds the word requested on the previous cycle.
  - scan_data, out, DW, equals mem_rdata (combinational).
- Host port:
  - host_valid, in, 1, host request pending.
  - host_we, in, 1, 1=write, 0=read.
  - host_addr, in, AW, host address.
  - host_wdata, in, DW, host write data.
  - host_ready, out, 1, request accepted this cycle when host_valid & host_ready.
  - host_rvalid, out, 1, host_rdata holds the read result (one-cycle pulse).
  - host_rdata, out, DW, equals mem_rdata (combinational).
  - host_starved, out, 1, sticky starvation flag, cleared only by rst.
- Memory port:
  - mem_wen, out, 1, memory write enable.
  - mem_addr, out, AW, memory address.
  - mem_wdata, out, DW, memory write data.
  - mem_rdata, in, DW, memory read data, valid 1 cycle after the address is presented.

## Operation
- One memory access per cycle; mem_* outputs are combinational from the current-cycle grant.
- Grant priority, highest first:
  1. scan_req=1: scan read. mem_addr=scan_addr, mem_wen=0.
  2. Write buffer non-empty (FB_WBUF_EN only): drain head entry. mem_wen=1.
  3. Accepted host request: mem_addr=host_addr; mem_wen=host_we; mem_wdata=host_wdata.
  4. Otherwise idle: mem_wen=0, mem_addr=0, mem_wdata=0.
- host_ready without FB_WBUF_EN is ~scan_req & ~rst.
- Host reads: host_rvalid=1 on the cycle after acceptance; no outstanding limit beyond one per cycle.
- Scan reads: scan_valid=1 on the cycle after scan_req=1, for every such cycle (back-to-back supported).
- scan_valid and host_rvalid are never both 1.
- Starvation counter (8-bit, saturating at 255):
  - increments each cycle host_valid=1 and host_ready=0;
  - clears on host acceptance, or when host_valid=0;
  - host_starved sets when counter == STARVE_LIMIT.
- Scan is never delayed by host activity; starvation is reported only, never resolved by preempting scan.
- Reset clears: scan_valid=0, host_rvalid=0, host_starved=0, starvation counter=0, write buffer empty.
- While rst=1: mem_wen=0 and host_ready=0.

## Timing
- Scan read latency: scan_req at cycle N gives scan_valid/scan_data at N+1.
- Host read latency: accepted at N gives host_rvalid/host_rdata at N+1.
- Host write: without the buffer, lands in memory at the accept edge.
- Read-after-write to the same address in consecutive accepted cycles returns the new data.
- Reset mid-operation:
  - an in-flight read's valid is suppressed (scan_valid/host_rvalid stay 0 the cycle after reset asserts);
  - buffered writes are discarded.
- scan_req and a host request in the same cycle: scan wins, host_ready=0, host holds its request stable.

## Configuration
- FB_WBUF_EN defined: adds a WBUF_DEPTH-entry FIFO of posted host writes.
  - Writes: host_ready=1 when the FIFO is not full (even while scan_req=1); accepted writes enqueue and drain only in cycles with scan_req=0, oldest first.
  - Reads: host_ready = ~scan_req & FIFO empty, so reads never bypass posted writes.
  - Simultaneous enqueue and dequeue in one cycle is allowed when full.
- FB_WBUF_EN undefined: no FIFO; behaviour as in Operation; WBUF_DEPTH ignored.

## Test plan
- Continuous scan_req for 64 cycles at addr 0..63 (mem[0]=0x00FF preloaded) -> scan_valid high cycles 1..64, scan_data=0x00FF at cycle 1, host_ready=0 throughout.
- Host write 0x1234 to addr 22, then read addr 22 on the next cycle, scan idle -> mem_wen pulse at accept, host_rvalid one cycle after read accept with host_rdata=0x1234.
- Host read pending while scan_req held high 64 cycles, STARVE_LIMIT=64 -> host_starved=1 on cycle 64, stays set after accept until rst.
- FB_WBUF_EN: 4 host writes during scan_req=1 -> all accepted, 5th stalls (host_ready=0); scan_req drops -> 4 consecutive mem_wen cycles in write order; host read waits until FIFO empty.
- Assert rst one cycle after a scan read and one buffered write -> no scan_valid pulse, FIFO empty, buffered write never reaches memory, all flags 0.

Source files
------------

// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: scan engine reads always win; host gets leftover cycles.
// Optional posted-write FIFO for the host enabled by defining FB_WBUF_EN.
module fb_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 64,
  parameter int WBUF_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic          scan_valid,
  output logic [DW-1:0] scan_data,
  input  logic          host_valid,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          host_starved,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || WBUF_DEPTH < 2 ||
      (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("fb_arbiter: illegal parameter value");
  end

  logic       scan_valid_q, scan_valid_d;
  logic       host_rvalid_q, host_rvalid_d;
  logic       host_starved_q, host_starved_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       host_acc, rd_acc;

`ifdef FB_WBUF_EN
  localparam int PW = $clog2(WBUF_DEPTH);

  logic [PW:0]                        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WBUF_DEPTH-1:0][AW+DW-1:0]   fifo_q, fifo_d;
  logic                               empty, full, deq, enq;

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    deq   = ~rst & ~scan_req & ~empty;
    // Reads wait for the FIFO to empty so they never overtake posted writes.
    if (rst)          host_ready = 1'b0;
    else if (host_we) host_ready = ~full | deq;
    else              host_ready = ~scan_req & empty;
    host_acc = host_valid & host_ready;
    enq      = host_acc & host_we;
    rd_acc   = host_acc & ~host_we;

    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (enq) begin
      fifo_d[wptr_q[PW-1:0]] = {host_addr, host_wdata};
      wptr_d = wptr_q + (PW+1)'(1);
    end
    if (deq) rptr_d = rptr_q + (PW+1)'(1);

    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (scan_req) begin
      mem_addr = scan_addr;
    end else if (deq) begin
      mem_wen                = 1'b1;
      {mem_addr, mem_wdata}  = fifo_q[rptr_q[PW-1:0]];
    end else if (rd_acc) begin
      mem_addr = host_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fifo_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fifo_q <= fifo_d;
    end
  end
`else
  always_comb begin
    host_ready = ~scan_req & ~rst;
    host_acc   = host_valid & host_ready;
    rd_acc     = host_acc & ~host_we;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (scan_req) begin
      mem_addr = scan_addr;
    end else if (host_acc) begin
      mem_wen   = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_we ? host_wdata : '0;
    end
  end
`endif

  always_comb begin
    scan_valid_d  = scan_req;
    host_rvalid_d = rd_acc;
    if (host_valid & ~host_ready)
      starve_cnt_d = (starve_cnt_q == 8'hFF) ? starve_cnt_q : starve_cnt_q + 8'd1;
    else
      starve_cnt_d = 8'd0;
    // Flag rises together with the counter reaching the limit.
    host_starved_d = host_starved_q | (starve_cnt_d == 8'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_valid_q   <= 1'b0;
      host_rvalid_q  <= 1'b0;
      host_starved_q <= 1'b0;
      starve_cnt_q   <= 8'd0;
    end else begin
      scan_valid_q   <= scan_valid_d;
      host_rvalid_q  <= host_rvalid_d;
      host_starved_q <= host_starved_d;
      starve_cnt_q   <= starve_cnt_d;
    end
  end

  assign scan_valid   = scan_valid_q;
  assign host_rvalid  = host_rvalid_q;
  assign host_starved = host_starved_q;
  assign scan_data    = mem_rdata;
  assign host_rdata   = mem_rdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: constant vector table, directed corner sequences and
// randomized traffic against a cycle-level reference of the arbitration rules.
module tb_fb_arbiter;
  localparam int LIMIT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_req = 1'b0;
  logic [9:0]  scan_addr = '0;
  logic        scan_valid;
  logic [15:0] scan_data;
  logic        host_valid = 1'b0;
  logic        host_we = 1'b0;
  logic [9:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ready, host_rvalid, host_starved;
  logic [15:0] host_rdata;
  logic        mem_wen;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  fb_arbiter #(.AW(10), .DW(16), .STARVE_LIMIT(LIMIT), .WBUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_valid(scan_valid), .scan_data(scan_data),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_starved(host_starved),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Pixel memory: synchronous write, registered read.
  logic [15:0] mem [0:1023];
  bit          init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0;
      mem[0]    <= 16'h00FF;
      init_done <= 1'b1;
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {
    logic        sr;
    logic [9:0]  sa;
    logic        hv;
    logic        hw;
    logic [9:0]  ha;
    logic [15:0] hd;
    logic        e_rdy;
    logic        e_wen;
    logic [9:0]  e_addr;
    logic [15:0] e_wdata;
    logic        e_sv;
    logic        e_rv;
    logic [15:0] e_data;
    logic        e_st;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] ref_mem [0:1023];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int sr, int sa, int hv, int hw, int ha, int hd,
                              int rdy, int wen, int addr, int wd, int sv, int rv, int d);
    vec_t v;
    v.sr = sr[0]; v.sa = sa[9:0]; v.hv = hv[0]; v.hw = hw[0]; v.ha = ha[9:0]; v.hd = hd[15:0];
    v.e_rdy = rdy[0]; v.e_wen = wen[0]; v.e_addr = addr[9:0]; v.e_wdata = wd[15:0];
    v.e_sv = sv[0]; v.e_rv = rv[0]; v.e_data = d[15:0]; v.e_st = 1'b0;
    return v;
  endfunction

  // One cycle: drive inputs, check at negedge, advance past the next posedge.
  task automatic step(input vec_t v, input string tag);
    scan_req = v.sr; scan_addr = v.sa;
    host_valid = v.hv; host_we = v.hw; host_addr = v.ha; host_wdata = v.hd;
    @(negedge clk);
    chk({tag, " host_ready"}, 32'(host_ready), 32'(v.e_rdy));
    chk({tag, " mem_wen"}, 32'(mem_wen), 32'(v.e_wen));
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
    chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(v.e_wdata));
    chk({tag, " scan_valid"}, 32'(scan_valid), 32'(v.e_sv));
    chk({tag, " host_rvalid"}, 32'(host_rvalid), 32'(v.e_rv));
    chk({tag, " host_starved"}, 32'(host_starved), 32'(v.e_st));
    if (v.e_sv) chk({tag, " scan_data"}, 32'(scan_data), 32'(v.e_data));
    if (v.e_rv) chk({tag, " host_rdata"}, 32'(host_rdata), 32'(v.e_data));
    if (v.e_wen) ref_mem[v.e_addr] = v.e_wdata;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    scan_req = 0; scan_addr = '0; host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    vec_t tbl [10];
    vec_t v;
    bit   pend_sv, pend_rv, starved_m, sr_on, acc;
    logic [15:0] pend_data;
    int   blk, sr_run;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0;
    ref_mem[0] = 16'h00FF;

    // Reset state, with a host write pending and rst held.
    rst = 1;
    repeat (2) @(posedge clk);
    #1 host_valid = 1; host_we = 1; host_addr = 10'd7; host_wdata = 16'hDEAD;
    @(negedge clk);
    chk("rst host_ready", 32'(host_ready), 0);
    chk("rst mem_wen", 32'(mem_wen), 0);
    chk("rst scan_valid", 32'(scan_valid), 0);
    chk("rst host_rvalid", 32'(host_rvalid), 0);
    chk("rst host_starved", 32'(host_starved), 0);
    do_reset();

    // Scan held 64 cycles over addr 0..63 with a host read blocked behind it.
    host_valid = 1; host_we = 0; host_addr = 10'd0;
    for (int i = 0; i <= 64; i++) begin
      scan_req = (i < 64); scan_addr = 10'(i);
      @(negedge clk);
      chk("scan64 host_ready", 32'(host_ready), 32'(i == 64));
      chk("scan64 scan_valid", 32'(scan_valid), 32'(i >= 1));
      if (i == 1)  chk("scan64 scan_data", 32'(scan_data), 32'h00FF);
      if (i == 63) chk("starve pre-limit", 32'(host_starved), 0);
      if (i == 64) chk("starve at limit", 32'(host_starved), 1);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    chk("starve read rvalid", 32'(host_rvalid), 1);
    chk("starve read data", 32'(host_rdata), 32'h00FF);
    chk("scan_valid drops", 32'(scan_valid), 0);
    repeat (3) @(posedge clk);
    #1 chk("starve sticky", 32'(host_starved), 1);
    do_reset();
    #1 chk("starve cleared by rst", 32'(host_starved), 0);

`ifdef FB_WBUF_EN
    // Four posted writes under scan, fifth stalls, then ordered drain.
    scan_req = 1; scan_addr = '0; host_valid = 1; host_we = 1;
    for (int i = 0; i < 5; i++) begin
      host_addr = 10'(100 + i); host_wdata = 16'(16'hA000 + i);
      @(negedge clk);
      chk("wbuf enq ready", 32'(host_ready), 32'(i < 4));
      chk("wbuf enq mem_wen", 32'(mem_wen), 0);
      @(posedge clk); #1;
    end
    scan_req = 0; host_we = 0; host_addr = 10'd100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wbuf drain wen", 32'(mem_wen), 1);
      chk("wbuf drain addr", 32'(mem_addr), 100 + i);
      chk("wbuf drain data", 32'(mem_wdata), 32'hA000 + i);
      chk("wbuf read blocked", 32'(host_ready), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("wbuf read ready", 32'(host_ready), 1);
    chk("wbuf read addr", 32'(mem_addr), 100);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("wbuf read rvalid", 32'(host_rvalid), 1);
    chk("wbuf read data", 32'(host_rdata), 32'hA000);
    @(posedge clk); #1;
`else
    tbl[0] = mk(0, 0, 1,1,22,'h1234, 1,1,22,'h1234, 0,0,0);
    tbl[1] = mk(0, 0, 1,0,22,0,      1,0,22,0,      0,0,0);
    tbl[2] = mk(0, 0, 0,0,0,0,       1,0,0,0,       0,1,'h1234);
    tbl[3] = mk(1, 0, 1,0,22,0,      0,0,0,0,       0,0,0);
    tbl[4] = mk(0, 0, 1,0,22,0,      1,0,22,0,      1,0,'h00FF);
    tbl[5] = mk(1,22, 1,1,3,'h5555,  0,0,22,0,      0,1,'h1234);
    tbl[6] = mk(0, 0, 1,1,3,'h5555,  1,1,3,'h5555,  1,0,'h1234);
    tbl[7] = mk(0, 0, 1,0,3,0,       1,0,3,0,       0,0,0);
    tbl[8] = mk(1, 3, 0,0,0,0,       0,0,3,0,       0,1,'h5555);
    tbl[9] = mk(0, 0, 0,0,0,0,       1,0,0,0,       1,0,'h5555);
    for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Random traffic: scan bursts of varying length, host on small address range.
    pend_sv = 0; pend_rv = 0; pend_data = '0; blk = 0; starved_m = 0; sr_run = 0; sr_on = 0;
    for (int k = 0; k < 500; k++) begin
      if (sr_run == 0) begin
        sr_on  = ($urandom_range(0, 2) == 0);
        sr_run = sr_on ? $urandom_range(1, 80) : $urandom_range(1, 6);
      end
      sr_run--;
      v = '0;
      v.sr = sr_on; v.sa = 10'($urandom_range(0, 15));
      v.hv = ($urandom_range(0, 3) != 0); v.hw = 1'($urandom_range(0, 1));
      v.ha = 10'($urandom_range(0, 15)); v.hd = 16'($urandom);
      acc       = v.hv && !v.sr;
      v.e_rdy   = !v.sr;
      v.e_wen   = acc && v.hw;
      v.e_addr  = v.sr ? v.sa : (acc ? v.ha : 10'd0);
      v.e_wdata = v.e_wen ? v.hd : 16'd0;
      v.e_sv = pend_sv; v.e_rv = pend_rv; v.e_data = pend_data; v.e_st = starved_m;
      pend_sv   = v.sr;
      pend_rv   = acc && !v.hw;
      pend_data = ref_mem[v.e_addr];
      blk = (v.hv && v.sr) ? ((blk < 255) ? blk + 1 : 255) : 0;
      if (blk == LIMIT) starved_m = 1;
      step(v, "rnd");
    end
    idle_inputs();
    @(posedge clk); #1;
`endif

    // Reset right after a scan read and a host write offered under scan.
    scan_req = 1; scan_addr = 10'd5; host_valid = 1; host_we = 1;
    host_addr = 10'd9; host_wdata = 16'h7777;
    @(posedge clk); #1;
    host_valid = 0;
    @(negedge clk);
    rst = 1; host_valid = 1;
    #1;
    chk("midrst host_ready", 32'(host_ready), 0);
    chk("midrst mem_wen", 32'(mem_wen), 0);
    @(posedge clk); #1;
    chk("midrst scan_valid", 32'(scan_valid), 0);
    chk("midrst host_rvalid", 32'(host_rvalid), 0);
    chk("midrst host_starved", 32'(host_starved), 0);
    idle_inputs();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("postrst no drain", 32'(mem_wen), 0);
    @(posedge clk); #1;
    host_valid = 1; host_we = 0; host_addr = 10'd9;
    @(negedge clk);
    chk("postrst read ready", 32'(host_ready), 1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("postrst rvalid", 32'(host_rvalid), 1);
    chk("postrst write discarded", 32'(host_rdata), 32'(ref_mem[9]));
    chk("postrst scan_valid", 32'(scan_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
